// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and default geometry for the cache block fill controller.
package cache_fill_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_WORDS  = 8;
    localparam int DEF_TAG_W  = 9;

    // Counters need one extra bit so a full block count (WORDS) is representable.
    localparam int OFFSET_W = $clog2(DEF_WORDS) + 1;

    localparam int CNT_ISSUE = 0;
    localparam int CNT_RECV  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int offset_w(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Miss/memory/cache-array bundle of the fill controller; master = controller side.
// crit_valid exists only when CACHE_FILL_CRIT_WORD_FIRST_EN is defined.
interface cache_fill_ctrl_if
    import cache_fill_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORDS  = DEF_WORDS,
    parameter int TAG_W  = DEF_TAG_W
);
    localparam int IDX_W = $clog2(WORDS);

    logic              miss_req;
    logic [ADDR_W-1:0] miss_addr;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              data_wen;
    logic [IDX_W-1:0]  word_idx;
    logic [DATA_W-1:0] fill_data;
    logic              tag_wen;
    logic [TAG_W-1:0]  fill_tag;
    logic              busy;
    logic              done;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    logic              crit_valid;

    modport master (
        input  miss_req, miss_addr, mem_valid, mem_data,
        output mem_ren, mem_addr, data_wen, word_idx, fill_data,
        output tag_wen, fill_tag, busy, done, crit_valid
    );
    modport slave (
        output miss_req, miss_addr, mem_valid, mem_data,
        input  mem_ren, mem_addr, data_wen, word_idx, fill_data,
        input  tag_wen, fill_tag, busy, done, crit_valid
    );
`else
    modport master (
        input  miss_req, miss_addr, mem_valid, mem_data,
        output mem_ren, mem_addr, data_wen, word_idx, fill_data,
        output tag_wen, fill_tag, busy, done
    );
    modport slave (
        output miss_req, miss_addr, mem_valid, mem_data,
        input  mem_ren, mem_addr, data_wen, word_idx, fill_data,
        input  tag_wen, fill_tag, busy, done
    );
`endif

endinterface

// File: rtl/cache_fill_ctrl_fill_counter.sv
// Saturating up-counter with synchronous clear; full flags a count of WORDS.
module fill_counter
    import cache_fill_ctrl_pkg::*;
#(
    parameter int WORDS = DEF_WORDS,
    parameter int CNT_W = OFFSET_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !full) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(WORDS));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache block fill: on a miss, read WORDS words from memory, stream them into the data array, then write the tag.
// Define CACHE_FILL_CRIT_WORD_FIRST_EN to fetch the missed word first and expose crit_valid.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORDS  = DEF_WORDS,
    parameter int TAG_W  = DEF_TAG_W
) (
    input logic               clk,
    input logic               rst,
    cache_fill_ctrl_if.master bus
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = offset_w(WORDS);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [ADDR_W-1:0] miss_base;
    logic [IDX_W-1:0]  start_idx;
    logic              capture;
    logic              mem_ren, data_wen, tag_wen, busy, done;

    logic [1:0]        cnt_en, cnt_full;
    logic [CNT_W-1:0]  cnt_val [2];
    logic [CNT_W-1:0]  issue_cnt, recv_cnt;
    logic              issue_full, recv_full;
    logic [IDX_W-1:0]  issue_slot, fetch_slot;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        fill_counter #(.WORDS(WORDS), .CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (capture),
            .en    (cnt_en[gi]),
            .count (cnt_val[gi]),
            .full  (cnt_full[gi])
        );
    end

    assign cnt_en[CNT_ISSUE] = mem_ren;
    assign cnt_en[CNT_RECV]  = data_wen;
    assign issue_cnt  = cnt_val[CNT_ISSUE];
    assign recv_cnt   = cnt_val[CNT_RECV];
    assign issue_full = cnt_full[CNT_ISSUE];
    assign recv_full  = cnt_full[CNT_RECV];

    assign capture   = (state_reg == IDLE) && bus.miss_req;
    assign miss_base = {bus.miss_addr[ADDR_W-1:CNT_W], {CNT_W{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg <= '0;
            tag_reg  <= '0;
        end else if (capture) begin
            base_reg <= miss_base;
            tag_reg  <= miss_base[ADDR_W-1 -: TAG_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.miss_req) state_next = FILL;
            FILL:    if (tag_wen) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Responses beyond the block (recv_full) are dropped rather than overwriting slot 0.
    always_comb begin
        mem_ren  = 1'b0;
        data_wen = 1'b0;
        tag_wen  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_reg)
            FILL: begin
                busy     = 1'b1;
                mem_ren  = !issue_full;
                data_wen = bus.mem_valid && !recv_full;
                tag_wen  = data_wen && (recv_cnt == CNT_W'(WORDS - 1));
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    logic [IDX_W-1:0] start_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_reg <= '0;
        end else if (capture) begin
            start_reg <= bus.miss_addr[IDX_W:1];
        end
    end

    assign start_idx      = start_reg;
    assign bus.crit_valid = data_wen && (recv_cnt == '0);
`else
    assign start_idx = '0;
`endif

    // Once all requests are out, the address stays on the last slot fetched.
    assign issue_slot = issue_full ? IDX_W'(WORDS - 1) : issue_cnt[IDX_W-1:0];
    assign fetch_slot = start_idx + issue_slot;

    assign bus.mem_ren   = mem_ren;
    assign bus.mem_addr  = base_reg + ADDR_W'({fetch_slot, 1'b0});
    assign bus.data_wen  = data_wen;
    assign bus.word_idx  = data_wen ? (start_idx + recv_cnt[IDX_W-1:0]) : '0;
    assign bus.fill_data = data_wen ? bus.mem_data : '0;
    assign bus.tag_wen   = tag_wen;
    assign bus.fill_tag  = tag_reg;
    assign bus.busy      = busy;
    assign bus.done      = done;

    logic spare_bits_unused;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    assign spare_bits_unused = ^{bus.miss_addr[0], issue_cnt[IDX_W]};
`else
    assign spare_bits_unused = ^{bus.miss_addr[CNT_W-1:0], issue_cnt[IDX_W]};
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomised self-checking bench for cache_fill_ctrl with an in-order, variable-latency memory model.
module tb_cache_fill_ctrl;
    import cache_fill_ctrl_pkg::*;

    localparam int WORDS = DEF_WORDS;

    typedef struct {
        logic        mem_ren;
        logic [15:0] mem_addr;
        logic        data_wen;
        logic [2:0]  word_idx;
        logic [15:0] fill_data;
        logic        tag_wen;
        logic [8:0]  fill_tag;
        logic        busy;
        logic        done;
        logic        mem_valid;
        logic        crit;
    } obs_t;

    logic clk;
    logic rst;

    cache_fill_ctrl_if bus ();

    cache_fill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_lat = 4;
    int          gap_mode = 0;
    bit          inject_valid = 0;
    logic [15:0] salt = 16'h5a5a;
    logic [15:0] rq_addr[$];
    int          rq_rdy[$];
    bit          gap_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9e37) ^ salt;
    endfunction

    function automatic logic [63:0] all_outs();
        logic [63:0] v;
        v = 64'({bus.mem_ren, bus.mem_addr, bus.data_wen, bus.word_idx, bus.fill_data,
                 bus.tag_wen, bus.fill_tag, bus.busy, bus.done});
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        v[63] = bus.crit_valid;
`endif
        return v;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: record each request, answer in order after mem_lat cycles, optionally with gaps.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            rq_addr.delete();
            rq_rdy.delete();
        end else if (bus.mem_ren === 1'b1) begin
            rq_addr.push_back(bus.mem_addr);
            rq_rdy.push_back(cyc + mem_lat);
        end
    end

    initial begin
        bus.mem_valid = 0;
        bus.mem_data  = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_valid = 0;
            bus.mem_data  = 16'($urandom);
            if (rst) begin
                rq_addr.delete();
                rq_rdy.delete();
                bus.mem_valid = inject_valid;
            end else if (rq_addr.size() > 0) begin
                if (rq_rdy[0] <= cyc && (gap_mode == 0 || (gap_mode == 1 && gap_pat[cyc % 7]) ||
                                         (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
                    bus.mem_valid = 1;
                    bus.mem_data  = mem_word(rq_addr[0]);
                    void'(rq_addr.pop_front());
                    void'(rq_rdy.pop_front());
                end
            end else if (inject_valid) begin
                bus.mem_valid = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        inject_valid = 1;
        rst = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs() !== 64'd0) begin $display("FAIL reset_state: outputs=%h required 0", all_outs()); n_fail++; end
        @(posedge clk);
        #1 rst = 0;
        inject_valid = 0;
        mem_lat = 2;
        gap_mode = 0;
        @(posedge clk);
        #1 bus.miss_req = 1; bus.miss_addr = 16'h1236;
        @(posedge clk);
        #1 bus.miss_req = 0;
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b1 || bus.tag_wen !== 1'b0) begin
                $display("FAIL midfill_state: busy=%b tag_wen=%b required busy=1 tag_wen=0", bus.busy, bus.tag_wen); n_fail++;
            end
        end
        #2 rst = 1;
        #1;
        n_checks++;
        if (all_outs() !== 64'd0) begin $display("FAIL reset_async: outputs=%h required 0", all_outs()); n_fail++; end
        @(negedge clk);
        n_checks++;
        if (all_outs() !== 64'd0) begin $display("FAIL reset_hold: outputs=%h required 0", all_outs()); n_fail++; end
        @(posedge clk);
        #2 rst = 0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b0 || bus.mem_ren !== 1'b0 || bus.tag_wen !== 1'b0) begin
                $display("FAIL reset_idle: busy=%b mem_ren=%b tag_wen=%b required 0", bus.busy, bus.mem_ren, bus.tag_wen); n_fail++;
            end
        end
        $display("reset: async mid-fill reset checked");
    endtask

    task automatic test_fill(input string name, input logic [15:0] addr, input int lat, input int gap, input bit spur);
        obs_t        obs[$];
        obs_t        o;
        logic [15:0] base, exp_addr, wr_addr, hold_addr;
        int          st, wr;
        bit          seen_done;
        mem_lat  = lat;
        gap_mode = gap;
        salt     = 16'($urandom);
        base     = addr & ~16'(2 * WORDS - 1);
        st       = 0;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        st = int'((addr >> 1) % WORDS);
`endif
        @(posedge clk);
        #1 bus.miss_req = 1; bus.miss_addr = addr;
        @(posedge clk);
        #1 bus.miss_req = 0; bus.miss_addr = 16'($urandom);
        seen_done = 0;
        for (int c = 0; c < 400 && !seen_done; c++) begin
            @(negedge clk);
            o.mem_ren   = bus.mem_ren;
            o.mem_addr  = bus.mem_addr;
            o.data_wen  = bus.data_wen;
            o.word_idx  = bus.word_idx;
            o.fill_data = bus.fill_data;
            o.tag_wen   = bus.tag_wen;
            o.fill_tag  = bus.fill_tag;
            o.busy      = bus.busy;
            o.done      = bus.done;
            o.mem_valid = bus.mem_valid;
            o.crit      = 1'b0;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
            o.crit      = bus.crit_valid;
`endif
            obs.push_back(o);
            seen_done = (bus.done === 1'b1);
            if (spur && !seen_done) begin
                bus.miss_req  = 1'($urandom_range(0, 1));
                bus.miss_addr = 16'($urandom);
            end
        end
        n_checks++;
        if (!seen_done) begin $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, obs.size()); n_fail++; end

        // A miss_req seen while in DONE must not start another fill.
        bus.miss_req = spur;
        @(posedge clk);
        #1 bus.miss_req = 0;
        @(negedge clk);
        hold_addr = base + 16'(2 * ((st + WORDS - 1) % WORDS));
        n_checks++;
        if ({bus.busy, bus.done, bus.mem_ren} !== 3'b000 || bus.mem_addr !== hold_addr) begin
            $display("FAIL %s_after: busy/done/ren=%b addr=%h required 000 addr=%h", name,
                     {bus.busy, bus.done, bus.mem_ren}, bus.mem_addr, hold_addr); n_fail++;
        end

        wr = 0;
        foreach (obs[i]) begin
            o = obs[i];
            exp_addr = base + 16'(2 * ((st + ((i < WORDS) ? i : WORDS - 1)) % WORDS));
            wr_addr  = base + 16'(2 * ((st + wr) % WORDS));
            n_checks += 6;
            if (o.mem_ren !== (i < WORDS && wr < WORDS)) begin
                $display("FAIL %s_mem_ren c%0d: got %b required %b", name, i, o.mem_ren, (i < WORDS && wr < WORDS)); n_fail++;
            end
            if (o.mem_addr !== exp_addr) begin
                $display("FAIL %s_mem_addr c%0d: got %h required %h", name, i, o.mem_addr, exp_addr); n_fail++;
            end
            if (o.busy !== (wr < WORDS)) begin
                $display("FAIL %s_busy c%0d: got %b required %b", name, i, o.busy, (wr < WORDS)); n_fail++;
            end
            if (o.done !== (wr == WORDS)) begin
                $display("FAIL %s_done c%0d: got %b required %b", name, i, o.done, (wr == WORDS)); n_fail++;
            end
            if (o.data_wen !== (o.mem_valid && wr < WORDS)) begin
                $display("FAIL %s_data_wen c%0d: got %b required %b", name, i, o.data_wen, (o.mem_valid && wr < WORDS)); n_fail++;
            end
            if (o.tag_wen !== (o.mem_valid && wr == WORDS - 1)) begin
                $display("FAIL %s_tag_wen c%0d: got %b required %b", name, i, o.tag_wen, (o.mem_valid && wr == WORDS - 1)); n_fail++;
            end
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
            n_checks++;
            if (o.crit !== (o.mem_valid && wr == 0)) begin
                $display("FAIL %s_crit_valid c%0d: got %b required %b", name, i, o.crit, (o.mem_valid && wr == 0)); n_fail++;
            end
`endif
            if (o.mem_valid && wr < WORDS) begin
                n_checks += 2;
                if (o.word_idx !== 3'((st + wr) % WORDS)) begin
                    $display("FAIL %s_word_idx w%0d: got %0d required %0d", name, wr, o.word_idx, (st + wr) % WORDS); n_fail++;
                end
                if (o.fill_data !== mem_word(wr_addr)) begin
                    $display("FAIL %s_fill_data w%0d: got %h required %h", name, wr, o.fill_data, mem_word(wr_addr)); n_fail++;
                end
                if (wr == WORDS - 1) begin
                    n_checks++;
                    if (o.fill_tag !== base[15:7]) begin
                        $display("FAIL %s_fill_tag: got %h required %h", name, o.fill_tag, base[15:7]); n_fail++;
                    end
                end
                wr++;
            end
        end
        n_checks++;
        if (wr != WORDS) begin $display("FAIL %s_writes: got %0d required %0d", name, wr, WORDS); n_fail++; end
        $display("fill %s: miss_addr=%h base=%h lat=%0d gap=%0d writes=%0d cycles=%0d", name, addr, base, lat, gap, wr, obs.size());
    endtask

    task automatic test_idle_valid();
        inject_valid = 1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if ({bus.data_wen, bus.tag_wen, bus.busy} !== 3'b000) begin
                $display("FAIL idle_valid: wen/tag/busy=%b required 000", {bus.data_wen, bus.tag_wen, bus.busy}); n_fail++;
            end
        end
        inject_valid = 0;
        @(negedge clk);
        $display("idle_valid: mem_valid in IDLE checked");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            test_fill("rand", 16'($urandom), int'($urandom_range(1, 6)), 2, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1;
        bus.miss_req  = 0;
        bus.miss_addr = 0;
        test_reset();
        test_fill("after_reset", 16'h0040, 3, 0, 0);
        test_fill("basic", 16'h1236, 4, 0, 0);
        test_fill("gapped", 16'h2468, 2, 1, 0);
        test_fill("spurious", 16'h0abc, 3, 0, 1);
        test_idle_valid();
        test_fill("wrap", 16'hfff2, 4, 0, 0);
        test_fill("crit", 16'h123a, 4, 0, 0);
        test_fill("lat1", 16'h8000, 1, 0, 0);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Read-side counterpart to the register/array write path: on a cache miss, reads one cache block from multi-cycle main memory.
- Streams each returned word into the cache data array, then writes the tag.
- Sits between the cache hit/miss logic and the main-memory port.
- Stalls the pipeline via busy while a fill is in progress.

Parameters:
- DATA_W, 16, memory word width in bits.
- ADDR_W, 16, byte address width.
- WORDS, 8, words per cache block (power of 2, ≥2).
- TAG_W, 9, tag width written to the tag array.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_req  in  1  miss detected; sampled only in IDLE.
- miss_addr  in  ADDR_W  byte address of the missing access.
- mem_ren  out  1  memory read request, one per cycle.
- mem_addr  out  ADDR_W  byte address of the current request.
- mem_valid  in  1  returned data valid; responses arrive in request order.
- mem_data  in  DATA_W  returned data.
- data_wen  out  1  cache data-array write enable.
- word_idx  out  log2(WORDS)  word slot being written.
- fill_data  out  DATA_W  data to the cache data array; equals mem_data.
- tag_wen  out  1  tag-array write enable.
- fill_tag  out  TAG_W  tag value, = base[ADDR_W-1 -: TAG_W].
- busy  out  1  fill in progress (pipeline stall).
- done  out  1  single-cycle pulse, the cycle after the last word is written.

Behaviour:
- Reset (async, active-high): state=IDLE; all counters, base, and captured tag are 0; every output is 0.
- States: IDLE, FILL, DONE.
- IDLE:
  - busy=0.
  - If miss_req=1: capture base = miss_addr with the low log2(WORDS)+1 bits cleared; capture the tag; clear issue_cnt and recv_cnt; go to FILL.
  - mem_valid in IDLE is ignored.
- FILL:
  - busy=1.
  - mem_ren=1 while issue_cnt<WORDS; mem_addr = base + 2*issue_cnt; issue_cnt++ each cycle. After that, mem_ren=0 and mem_addr holds its last value.
  - Each mem_valid=1 (combinational, same cycle): data_wen=1, word_idx=recv_cnt, fill_data=mem_data; recv_cnt++.
  - On the response with recv_cnt==WORDS-1: tag_wen=1 in that same cycle; next state DONE.
  - miss_req is ignored in FILL.
  - Responses may overlap issues (pipelined memory); arbitrary gaps are tolerated.
- DONE: done=1, busy=0, then IDLE unconditionally. A miss_req in DONE is ignored; the requester holds miss_req until it sees busy.
- Latency: fill completes WORDS valid responses after entry; minimum fill duration is WORDS cycles plus memory latency.
- Width rules: counters are log2(WORDS)+1 bits so that a full count (WORDS) is distinguishable. Address arithmetic is modulo 2^ADDR_W.
- Extra mem_valid after recv_cnt reaches WORDS: ignored, no write.
- Reset mid-fill: returns to IDLE immediately; data already written stays, tag is not written. Memory shares rst, so there are no stale responses.

Optional Feature:
- Macro: CACHE_FILL_CRIT_WORD_FIRST_EN.
- Defined:
  - Fetch starts at the missed word: start = miss_addr[log2(WORDS):1].
  - mem_addr = base + 2*((start+issue_cnt) mod WORDS).
  - word_idx = (start+recv_cnt) mod WORDS.
  - The index wraps from WORDS-1 to 0.
  - An extra output crit_valid pulses on the first response; the pipeline may forward it early.
- Undefined: start=0 always; crit_valid is absent.

Decomposition:
- Shared package holds: the state enum (IDLE/FILL/DONE), the DATA_W/ADDR_W/WORDS/TAG_W defaults, and a constant OFFSET_W = log2(WORDS)+1.
- One natural sub-module: fill_counter, an up-counter with clear, enable and full flag, instantiated twice (issue, recv).

Test Plan:
1. Reset mid-fill: rst asserted during an active fill → all outputs 0 in the same cycle; state IDLE; a new miss_req at 0x0040 then fills normally.
2. Basic fill, latency 4:
   - Stimulus: miss_addr=0x1236, WORDS=8.
   - Required: mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles.
   - Required: 8 data_wen with word_idx 0..7 and fill_data matching mem_data.
   - Required: tag_wen on the 8th write, fill_tag=0x1230>>7, done 1 cycle later.
3. Gapped responses: mem_valid pattern 1,0,0,1,1,0,1,… → writes only on valid cycles; busy held until the 8th valid.
4. Spurious inputs:
   - miss_req pulses during FILL and DONE → ignored, no address change.
   - mem_valid in IDLE → no data_wen.
5. Critical-word-first (macro defined): miss_addr=0x123A → word_idx order 5,6,7,0,1,2,3,4; mem_addr 0x123A,0x123C,0x123E,0x1230…; crit_valid on the first response only.
6. Address wrap: miss_addr=0xFFF2 → mem_addr 0xFFF0..0xFFFE with no carry past 16 bits; tag correct.
